// File: rtl/ultra_ranger.sv
// HC-SR04 front end: fires the trigger, times the echo pulse
// and publishes its width in microseconds.
module ultra_ranger #(
  parameter int CLK_PER_US = 27,
  parameter int TRIG_US    = 10,
  parameter int TIMEOUT_US = 30000,
  parameter int PERIOD_US  = 60000
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        en,
  input  logic        echo,
  output logic        trig,
  output logic [15:0] measure,
  output logic        valid,
  output logic        timeout,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    MEASURE,
    HOLDOFF
  } state_t;

  localparam int PW = $clog2(CLK_PER_US + 1);
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_PER_US - 1);
  localparam logic [15:0] TRIG_T = 16'(TRIG_US);
  localparam logic [15:0] TO_T = 16'(TIMEOUT_US);
  localparam logic [16:0] PER_T = 17'(PERIOD_US);

  state_t state, state_n;

  logic [1:0]    echo_sync;
  logic          echo_s;
  logic [PW-1:0] pre;
  logic          us_tick;
  logic [15:0]   us_cnt;
  logic [16:0]   per_cnt;
  logic          meas_done;
  logic          to_hit;

  assign echo_s  = echo_sync[1];
  assign us_tick = (pre == PRE_MAX);
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      echo_sync <= '0;
      pre       <= '0;
    end else begin
      echo_sync <= {echo_sync[0], echo};
      pre       <= us_tick ? '0 : pre + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n   = state;
    meas_done = 1'b0;
    to_hit    = 1'b0;
    unique case (state)
      IDLE: begin
        if (en) state_n = TRIG;
      end
      TRIG: begin
        if (us_tick && us_cnt == TRIG_T)
          state_n = WAIT_RISE;
      end
      WAIT_RISE: begin
        if (echo_s) begin
          state_n = MEASURE;
        end else if (us_cnt == TO_T) begin
          to_hit  = 1'b1;
          state_n = HOLDOFF;
        end
      end
      MEASURE: begin
        // a fall seen together with the limit still counts
        if (!echo_s) begin
          meas_done = 1'b1;
          state_n   = HOLDOFF;
        end else if (us_cnt == TO_T) begin
          to_hit  = 1'b1;
          state_n = HOLDOFF;
        end
      end
      HOLDOFF: begin
        if (per_cnt >= PER_T)
          state_n = en ? TRIG : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      us_cnt  <= '0;
      per_cnt <= '0;
    end else begin
      if (state_n != state)
        us_cnt <= '0;
      else if (us_tick && us_cnt != '1)
        us_cnt <= us_cnt + 16'd1;
      // period runs from each trigger start
      if (state_n == TRIG && state != TRIG)
        per_cnt <= '0;
      else if (us_tick && per_cnt != '1)
        per_cnt <= per_cnt + 17'd1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      trig    <= 1'b0;
      valid   <= 1'b0;
      measure <= '0;
      timeout <= 1'b0;
    end else begin
      trig  <= (state_n == TRIG);
      valid <= meas_done;
      if (meas_done) begin
        measure <= us_cnt;
        timeout <= 1'b0;
      end else if (to_hit) begin
        timeout <= 1'b1;
      end
    end
  end

endmodule
